// File: rtl/crc_net_pkg.sv
// Shared definitions for the CRC-8 framed serial link (transmitter and receiver):
// FSM states, framing constants and header field layout.
package crc_net_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        HDR   = 3'd2,
        PAY   = 3'd3,
        CRC   = 3'd4,
        GAP   = 3'd5
    } tx_state_e;

    localparam logic [7:0] START_BYTE = 8'hA5;
    localparam logic [7:0] CRC8_POLY  = 8'h07;

    localparam int DEST_W = 2;
    localparam int SRC_W  = 2;
    localparam int LEN_W  = 4;

    function automatic logic [7:0] make_hdr(input logic [DEST_W-1:0] dest,
                                            input logic [SRC_W-1:0]  src,
                                            input logic [LEN_W-1:0]  len);
        return {dest, src, len};
    endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 (polynomial from crc_net_pkg, init 0, MSB first); shared by TX and RX.
module crc8_serial
    import crc_net_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [7:0] crc
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;
    logic       feedback;

    always_comb begin
        feedback = crc_q[7] ^ bit_in;
        crc_d    = crc_q;
        if (clr) begin
            crc_d = 8'h00;
        end else if (en) begin
            crc_d = {crc_q[6:0], 1'b0} ^ (feedback ? CRC8_POLY : 8'h00);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/crc_frame_tx.sv
// Framed serial transmitter: START, HDR, payload, CRC-8, idle gap; MSB first, idle high.
// Optional CRC fault injection (crc_corrupt port) is enabled by defining CRC_TX_FAULT_INJECT_EN.
module crc_frame_tx
    import crc_net_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int GAP_BITS     = 8
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tx_start,
    input  logic [127:0] tx_data,
    input  logic [3:0]   tx_len,
    input  logic [1:0]   tx_dest_id,
    input  logic [1:0]   my_id,
`ifdef CRC_TX_FAULT_INJECT_EN
    input  logic         crc_corrupt,
`endif
    output logic         tx_serial,
    output logic         tx_busy,
    output logic         tx_done
);

    localparam logic [7:0] CPB_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_BITS - 1);

    tx_state_e    state_q, state_d;
    logic [7:0]   clk_cnt_q, clk_cnt_d;
    logic [7:0]   bit_cnt_q, bit_cnt_d;
    logic [3:0]   byte_cnt_q, byte_cnt_d;
    logic [7:0]   shift_q, shift_d;
    logic [127:0] data_q, data_d;
    logic [3:0]   len_q, len_d;
    logic [1:0]   dest_q, dest_d;
    logic [1:0]   src_q, src_d;
    logic         serial_q, serial_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         accept;
    logic [7:0]   crc_val;
    logic [7:0]   crc_mask;
    logic         bit_end;
    logic         byte_end;

`ifdef CRC_TX_FAULT_INJECT_EN
    logic corrupt_q, corrupt_d;

    always_comb begin
        corrupt_d = corrupt_q;
        if (accept) begin
            corrupt_d = crc_corrupt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corrupt_q <= 1'b0;
        end else begin
            corrupt_q <= corrupt_d;
        end
    end

    assign crc_mask = {7'd0, corrupt_q};
`else
    assign crc_mask = 8'h00;
`endif

    assign accept   = (state_q == IDLE) && tx_start;
    assign bit_end  = (clk_cnt_q == CPB_LAST);
    assign byte_end = (bit_cnt_q == 8'd7);

    // Each HDR/PAY bit enters the CRC on the first clock of its bit period, so the
    // register already holds the final value when the FSM moves into CRC.
    crc8_serial u_crc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (accept),
        .en     ((state_q == HDR || state_q == PAY) && clk_cnt_q == 8'd0),
        .bit_in (shift_q[7]),
        .crc    (crc_val)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        len_d      = len_q;
        dest_d     = dest_q;
        src_d      = src_q;
        done_d     = 1'b0;

        if (state_q == IDLE) begin
            if (tx_start) begin
                data_d    = tx_data;
                len_d     = tx_len;
                dest_d    = tx_dest_id;
                src_d     = my_id;
                clk_cnt_d = 8'd0;
                bit_cnt_d = 8'd0;
                shift_d   = START_BYTE;
                state_d   = START;
            end
        end else if (!bit_end) begin
            clk_cnt_d = clk_cnt_q + 8'd1;
        end else begin
            clk_cnt_d = 8'd0;
            bit_cnt_d = bit_cnt_q + 8'd1;
            shift_d   = {shift_q[6:0], 1'b0};
            case (state_q)
                START: if (byte_end) begin
                    bit_cnt_d = 8'd0;
                    shift_d   = make_hdr(dest_q, src_q, len_q);
                    state_d   = HDR;
                end
                HDR: if (byte_end) begin
                    bit_cnt_d = 8'd0;
                    if (len_q != 4'd0) begin
                        byte_cnt_d = 4'd0;
                        shift_d    = data_q[127:120];
                        data_d     = data_q << 8;
                        state_d    = PAY;
                    end else begin
                        shift_d = crc_val ^ crc_mask;
                        state_d = CRC;
                    end
                end
                PAY: if (byte_end) begin
                    bit_cnt_d = 8'd0;
                    if (byte_cnt_q == len_q - 4'd1) begin
                        shift_d = crc_val ^ crc_mask;
                        state_d = CRC;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 4'd1;
                        shift_d    = data_q[127:120];
                        data_d     = data_q << 8;
                    end
                end
                CRC: if (byte_end) begin
                    bit_cnt_d = 8'd0;
                    state_d   = GAP;
                end
                GAP: if (bit_cnt_q == GAP_LAST) begin
                    bit_cnt_d = 8'd0;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d   = (state_d != IDLE);
        serial_d = (state_d == IDLE || state_d == GAP) ? 1'b1 : shift_d[7];
    end

    // NOTE: the 128-bit payload register is reset too, so a fresh device never frames stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            clk_cnt_q  <= 8'd0;
            bit_cnt_q  <= 8'd0;
            byte_cnt_q <= 4'd0;
            shift_q    <= 8'd0;
            data_q     <= '0;
            len_q      <= 4'd0;
            dest_q     <= 2'd0;
            src_q      <= 2'd0;
            serial_q   <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            len_q      <= len_d;
            dest_q     <= dest_d;
            src_q      <= src_d;
            serial_q   <= serial_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx_serial = serial_q;
    assign tx_busy   = busy_q;
    assign tx_done   = done_q;

endmodule

// File: tb/tb_crc_frame_tx.sv
// Self-checking bench for crc_frame_tx: directed framing cases plus random frames against a
// byte-level frame/CRC model. Exercises crc_corrupt when CRC_TX_FAULT_INJECT_EN is defined.
module tb_crc_frame_tx;

    localparam int CPB = 4;
    localparam int GAP = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         tx_start;
    logic [127:0] tx_data;
    logic [3:0]   tx_len;
    logic [1:0]   tx_dest_id;
    logic [1:0]   my_id;
    logic         crc_corrupt;
    logic         tx_serial;
    logic         tx_busy;
    logic         tx_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_bytes[$];
    logic [7:0] last_crc;

    always #5 clk = ~clk;

    crc_frame_tx #(
        .CLKS_PER_BIT (CPB),
        .GAP_BITS     (GAP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_len      (tx_len),
        .tx_dest_id  (tx_dest_id),
        .my_id       (my_id),
`ifdef CRC_TX_FAULT_INJECT_EN
        .crc_corrupt (crc_corrupt),
`endif
        .tx_serial   (tx_serial),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // CRC-8, poly 0x07, init 0, processed byte by byte.
    function automatic logic [7:0] crc8_model(input logic [7:0] bytes[$]);
        logic [7:0] c = 8'h00;
        foreach (bytes[i]) begin
            c = c ^ bytes[i];
            for (int k = 0; k < 8; k++) begin
                c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
            end
        end
        return c;
    endfunction

    function automatic void build_frame(input logic [1:0] dest, input logic [1:0] src,
                                        input logic [3:0] len, input logic [127:0] data,
                                        input bit corrupt);
        logic [7:0] covered[$];
        logic [7:0] c;
        exp_bytes = {};
        covered   = {};
        exp_bytes.push_back(8'hA5);
        covered.push_back({dest, src, len});
        for (int i = 0; i < int'(len); i++) begin
            covered.push_back(data[127 - 8*i -: 8]);
        end
        foreach (covered[i]) exp_bytes.push_back(covered[i]);
        c = crc8_model(covered);
        exp_bytes.push_back(corrupt ? (c ^ 8'h01) : c);
    endfunction

    task automatic scramble_inputs();
        tx_data    = {$urandom, $urandom, $urandom, $urandom};
        tx_len     = 4'($urandom);
        tx_dest_id = 2'($urandom);
        my_id      = 2'($urandom);
        crc_corrupt = 1'($urandom);
    endtask

    // Called at a negedge; pulses tx_start for one cycle and returns at the next negedge,
    // which is the first cycle the frame should be in flight.
    task automatic start_frame(input logic [1:0] dest, input logic [1:0] src,
                               input logic [3:0] len, input logic [127:0] data,
                               input bit corrupt);
        tx_data     = data;
        tx_len      = len;
        tx_dest_id  = dest;
        my_id       = src;
        crc_corrupt = corrupt;
        tx_start    = 1'b1;
`ifdef CRC_TX_FAULT_INJECT_EN
        build_frame(dest, src, len, data, corrupt);
`else
        build_frame(dest, src, len, data, 1'b0);
`endif
        @(negedge clk);
        tx_start = 1'b0;
        scramble_inputs();
    endtask

    // Follows the frame cycle by cycle; ends at the negedge of the cycle tx_busy drops.
    task automatic watch_frame(input string name, input int mid_start);
        int         nb      = exp_bytes.size();
        int         exp_cyc = (8*nb + GAP) * CPB;
        int         c       = 0;
        int         bad     = 0;
        int         dones   = 0;
        int         b;
        logic       eb;
        logic [7:0] tmp;
        logic [7:0] acc     = 8'h00;
        logic [7:0] got[$];
        while (tx_busy === 1'b1 && c < exp_cyc + 64) begin
            b = c / CPB;
            if (b < 8*nb) begin
                tmp = exp_bytes[b/8];
                eb  = tmp[7 - (b % 8)];
            end else begin
                eb = 1'b1;
            end
            if (tx_serial !== eb) bad++;
            if (tx_done !== 1'b0) dones++;
            if ((c % CPB) == CPB/2 && b < 8*nb) begin
                acc = {acc[6:0], tx_serial};
                if ((b % 8) == 7) got.push_back(acc);
            end
            tx_start = (c == mid_start);
            @(negedge clk);
            c++;
        end
        tx_start = 1'b0;
        check({name, "_busy_cycles"}, c, exp_cyc);
        check({name, "_serial_bad_cycles"}, bad, 0);
        check({name, "_done_while_busy"}, dones, 0);
        check({name, "_done_pulse"}, tx_done, 1'b1);
        check({name, "_byte_count"}, got.size(), nb);
        for (int i = 0; i < nb && i < got.size(); i++) begin
            check($sformatf("%s_byte%0d", name, i), got[i], exp_bytes[i]);
        end
        last_crc = (got.size() == nb) ? got[nb-1] : 8'hxx;
    endtask

    task automatic idle_check(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({name, "_idle_busy"}, tx_busy, 1'b0);
            check({name, "_idle_done"}, tx_done, 1'b0);
            check({name, "_idle_serial"}, tx_serial, 1'b1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]   d, s;
        logic [3:0]   l;
        logic [127:0] dat;

        rst_n       = 1'b0;
        tx_start    = 1'b0;
        tx_data     = '0;
        tx_len      = '0;
        tx_dest_id  = '0;
        my_id       = '0;
        crc_corrupt = 1'b0;

        #12;
        check("reset_serial", tx_serial, 1'b1);
        check("reset_busy", tx_busy, 1'b0);
        check("reset_done", tx_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_check("post_reset", 2);

        // A5 01 00 15
        start_frame(2'd0, 2'd0, 4'd1, 128'd0, 1'b0);
        watch_frame("len1", -1);
        check("len1_crc_const", last_crc, 8'h15);
        idle_check("len1", 2);

        // A5 60 27, no payload
        start_frame(2'd1, 2'd2, 4'd0, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        watch_frame("len0", -1);
        check("len0_crc_const", last_crc, 8'h27);
        idle_check("len0", 2);

        start_frame(2'd0, 2'd0, 4'd4, {32'hDEADBEEF, 96'd0}, 1'b0);
        watch_frame("deadbeef", -1);
        idle_check("deadbeef", 1);

        // Start mid-frame is dropped; then a start in the tx_done cycle runs back-to-back.
        start_frame(2'd3, 2'd1, 4'd2, {16'h1234, 112'd0}, 1'b0);
        watch_frame("midstart", 70);
        start_frame(2'd2, 2'd3, 4'd3, {24'hC0FFEE, 104'd0}, 1'b0);
        watch_frame("b2b", -1);
        idle_check("b2b", 3);

        // Reset during PAY abandons the frame.
        start_frame(2'd1, 2'd1, 4'd5, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        repeat (16*CPB + 6) @(negedge clk);
        check("pre_reset_busy", tx_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midreset_serial", tx_serial, 1'b1);
        check("midreset_busy", tx_busy, 1'b0);
        check("midreset_done", tx_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_check("after_reset", 2);
        start_frame(2'd2, 2'd1, 4'd6, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        watch_frame("after_reset_frame", -1);
        idle_check("after_reset_frame", 1);

`ifdef CRC_TX_FAULT_INJECT_EN
        start_frame(2'd0, 2'd0, 4'd1, 128'd0, 1'b1);
        watch_frame("corrupt", -1);
        check("corrupt_crc_const", last_crc, 8'h14);
        idle_check("corrupt", 1);
`endif

        for (int n = 0; n < 10; n++) begin
            d   = 2'($urandom);
            s   = 2'($urandom);
            l   = 4'($urandom);
            dat = {$urandom, $urandom, $urandom, $urandom};
            start_frame(d, s, l, dat, 1'b0);
            watch_frame($sformatf("rnd%0d", n), ($urandom % 2) ? int'($urandom_range(1, 150)) : -1);
            if ($urandom % 2) begin
                idle_check($sformatf("rnd%0d", n), int'($urandom_range(1, 3)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
